// File: rtl/register_params.sv
// Shared defaults and index helpers for the scoreboarded register file.
package register_params;

    localparam int unsigned DEFAULT_NUM_REGS       = 16;
    localparam int unsigned DEFAULT_DATA_WIDTH     = 32;
    localparam int unsigned DEFAULT_NUM_READ_PORTS = 2;
    localparam int unsigned DEFAULT_NUM_WB_PORTS   = 2;
    localparam int unsigned MAX_REGS               = 256;

    function automatic int unsigned idx_width(input int unsigned num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    // Wide one-hot decode; callers truncate to their own register count.
    function automatic logic [MAX_REGS-1:0] idx_onehot(input int unsigned idx);
        return MAX_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// One architectural register: data word plus its write-reservation bit.
module scoreboard_entry
    import register_params::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  set_busy,
    input  logic                  clr_busy,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  busy
);

    logic [DATA_WIDTH-1:0] data_d, data_q;
    logic                  busy_d, busy_q;

    // A new reservation takes precedence over a same-cycle release.
    always_comb begin
        data_d = data_q;
        busy_d = busy_q;
        if (wr_en) begin
            data_d = wr_data;
        end
        if (set_busy) begin
            busy_d = 1'b1;
        end else if (clr_busy) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
            busy_q <= 1'b0;
        end else begin
            data_q <= data_d;
            busy_q <= busy_d;
        end
    end

    assign data = data_q;
    assign busy = busy_q;

endmodule

// File: rtl/scoreboard_register_file.sv
// Register file with per-register reservation scoreboard and multi-port write-back.
// Optional same-cycle write-back forwarding to reads: define REGFILE_WB_BYPASS_EN.
module scoreboard_register_file
    import register_params::*;
#(
    parameter  int unsigned NUM_REGS       = DEFAULT_NUM_REGS,
    parameter  int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter  int unsigned NUM_READ_PORTS = DEFAULT_NUM_READ_PORTS,
    parameter  int unsigned NUM_WB_PORTS   = DEFAULT_NUM_WB_PORTS,
    localparam int unsigned IDX_W          = idx_width(NUM_REGS)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 reserve_valid,
    input  logic [IDX_W-1:0]                     reserve_idx,
    output logic                                 reserve_accept,
    input  logic [NUM_READ_PORTS*IDX_W-1:0]      read_idx,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] read_data,
    output logic [NUM_READ_PORTS-1:0]            read_busy,
    output logic                                 issue_stall,
    input  logic [NUM_WB_PORTS-1:0]              wb_valid,
    input  logic [NUM_WB_PORTS*IDX_W-1:0]        wb_idx,
    input  logic [NUM_WB_PORTS*DATA_WIDTH-1:0]   wb_data,
    output logic                                 wb_error,
    output logic [IDX_W:0]                       outstanding_count
);

    localparam int unsigned CNT_W = IDX_W + 1;

    logic [DATA_WIDTH-1:0] reg_data [NUM_REGS];
    logic [NUM_REGS-1:0]   reg_busy;
    logic [NUM_REGS-1:0]   wb_hit;
    logic [DATA_WIDTH-1:0] wb_sel [NUM_REGS];
    logic [NUM_REGS-1:0]   res_set;
    logic                  wb_conflict;
    logic                  wb_unreserved;
    logic [CNT_W-1:0]      count_d, count_q;
    logic                  wb_error_d, wb_error_q;

    // Per-register write-back select; walking ports high to low leaves the lowest port winning.
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx    = '0;
        wb_hit = '0;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            wb_sel[r] = '0;
        end
        for (int p = int'(NUM_WB_PORTS) - 1; p >= 0; p--) begin
            if (wb_valid[p]) begin
                idx         = wb_idx[p*IDX_W +: IDX_W];
                wb_hit[idx] = 1'b1;
                wb_sel[idx] = wb_data[p*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        wb_hit[0] = 1'b0;
    end

    always_comb begin
        logic [IDX_W-1:0] idx_p;
        idx_p         = '0;
        wb_conflict   = 1'b0;
        wb_unreserved = 1'b0;
        for (int p = 0; p < int'(NUM_WB_PORTS); p++) begin
            idx_p = wb_idx[p*IDX_W +: IDX_W];
            if (wb_valid[p] && (idx_p != '0) && !reg_busy[idx_p]) begin
                wb_unreserved = 1'b1;
            end
            for (int q = p + 1; q < int'(NUM_WB_PORTS); q++) begin
                if (wb_valid[p] && wb_valid[q] && (idx_p != '0) &&
                    (idx_p == wb_idx[q*IDX_W +: IDX_W])) begin
                    wb_conflict = 1'b1;
                end
            end
        end
        wb_error_d = wb_conflict | wb_unreserved;
    end

    // A busy target can still be reserved when it is being released this cycle.
    always_comb begin
        int unsigned released;
        released       = 0;
        reserve_accept = reserve_valid &&
                         ((reserve_idx == '0) || !reg_busy[reserve_idx] || wb_hit[reserve_idx]);
        res_set        = '0;
        if (reserve_accept && (reserve_idx != '0)) begin
            res_set = NUM_REGS'(idx_onehot(32'(reserve_idx)));
        end
        for (int r = 1; r < int'(NUM_REGS); r++) begin
            if (wb_hit[r] && reg_busy[r]) begin
                released += 1;
            end
        end
        count_d = count_q + CNT_W'(res_set != '0) - CNT_W'(released);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q    <= '0;
            wb_error_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wb_error_q <= wb_error_d;
        end
    end

    assign reg_data[0] = '0;
    assign reg_busy[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        scoreboard_entry #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_entry (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wb_hit[r]),
            .wr_data  (wb_sel[r]),
            .set_busy (res_set[r]),
            .clr_busy (wb_hit[r]),
            .data     (reg_data[r]),
            .busy     (reg_busy[r])
        );
    end

    always_comb begin
        logic [IDX_W-1:0] ridx;
        ridx      = '0;
        read_data = '0;
        read_busy = '0;
        for (int p = 0; p < int'(NUM_READ_PORTS); p++) begin
            ridx                                  = read_idx[p*IDX_W +: IDX_W];
            read_data[p*DATA_WIDTH +: DATA_WIDTH] = reg_data[ridx];
            read_busy[p]                          = reg_busy[ridx];
`ifdef REGFILE_WB_BYPASS_EN
            if (wb_hit[ridx]) begin
                read_data[p*DATA_WIDTH +: DATA_WIDTH] = wb_sel[ridx];
                read_busy[p]                          = 1'b0;
            end
`endif
        end
    end

    assign issue_stall       = (|read_busy) | (reserve_valid & ~reserve_accept);
    assign wb_error          = wb_error_q;
    assign outstanding_count = count_q;

endmodule
